// File: rtl/wb_master_mem_tester.sv
// wb_master_mem_tester: Wishbone B4 classic master sweeping a write pass then a read-compare pass, with retry/timeout status.
// Define WB_MTEST_HALT_ON_FAIL_EN to stop all bus traffic at the first read mismatch.
module wb_master_mem_tester #(
    parameter int          ADDR_WIDTH  = 16,
    parameter int          DATA_WIDTH  = 32,
    parameter int          START_ADDR  = 0,
    parameter int          END_ADDR    = 15,
    parameter int          STEP        = 1,
    parameter logic [31:0] SEED        = 32'hA5A5,
    parameter int          INIT_CYCLES = 4,
    parameter int          TIMEOUT     = 255,
    parameter int          MAX_RETRY   = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [ADDR_WIDTH-1:0]     adr_o,
    output logic [DATA_WIDTH-1:0]     dat_o,
    output logic [DATA_WIDTH/8-1:0]   sel_o,
    input  logic [DATA_WIDTH-1:0]     dat_i,
    input  logic                      ack_i,
    input  logic                      err_i,
    output logic                      busy_o,
    output logic                      pass_done_o,
    output logic [15:0]               pass_cnt_o,
    output logic [15:0]               mismatch_cnt_o,
    output logic                      fault_o,
    output logic [ADDR_WIDTH-1:0]     fail_adr_o
);
    localparam int TW  = $clog2(TIMEOUT + 2);
    localparam int RW  = $clog2(MAX_RETRY + 2);
    localparam int IW  = $clog2(INIT_CYCLES + 2);
    localparam int AW1 = ADDR_WIDTH + 1;
    localparam logic [TW-1:0]         TO_LIM  = TW'(TIMEOUT);
    localparam logic [RW-1:0]         RT_LIM  = RW'(MAX_RETRY);
    localparam logic [IW-1:0]         IN_LIM  = IW'(INIT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] A_START = ADDR_WIDTH'(START_ADDR);
    localparam logic [AW1-1:0]        A_END   = AW1'(END_ADDR);
    localparam logic [AW1-1:0]        A_STEP  = AW1'(STEP);

    typedef enum logic [2:0] {S_WAIT_INIT, S_IDLE, S_REQ, S_WAIT, S_NEXT} state_t;

    state_t                r_state;
    logic [IW-1:0]         r_init;
    logic [TW-1:0]         r_tcnt;
    logic [RW-1:0]         r_retry;
    logic [ADDR_WIDTH-1:0] r_cur;
    logic                  r_rd;
    logic                  r_cyc;
    logic                  r_stb;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_pass_done;
    logic [15:0]           r_pass_cnt;
    logic [15:0]           r_mis;
    logic                  r_fault;
    logic [ADDR_WIDTH-1:0] r_fail_adr;

    logic [DATA_WIDTH-1:0] w_pat;
    logic [AW1-1:0]        w_nxt;
    logic                  w_wrap;

    // Pattern depends on pass_cnt so consecutive passes write distinct data.
    assign w_pat  = DATA_WIDTH'(SEED) + DATA_WIDTH'(r_cur) + DATA_WIDTH'(r_pass_cnt);
    assign w_nxt  = {1'b0, r_cur} + A_STEP;
    assign w_wrap = w_nxt > A_END;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_WAIT_INIT;
            r_init      <= '0;
            r_tcnt      <= '0;
            r_retry     <= '0;
            r_cur       <= A_START;
            r_rd        <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= A_START;
            r_dat       <= '0;
            r_pass_done <= 1'b0;
            r_pass_cnt  <= '0;
            r_mis       <= '0;
            r_fault     <= 1'b0;
            r_fail_adr  <= '0;
        end else begin
            r_pass_done <= 1'b0;
            case (r_state)
                S_WAIT_INIT: begin
                    r_init  <= r_init + IW'(1);
                    r_state <= (r_init + IW'(1) >= IN_LIM) ? S_IDLE : S_WAIT_INIT;
                end
                S_IDLE: r_state <= (en_i && !r_fault) ? S_REQ : S_IDLE;
                S_REQ: begin
                    r_cyc   <= 1'b1;
                    r_stb   <= 1'b1;
                    r_we    <= ~r_rd;
                    r_adr   <= r_cur;
                    r_dat   <= w_pat;
                    r_tcnt  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ack_i) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_retry <= '0;
                        r_state <= S_NEXT;
                        if (r_rd && dat_i != w_pat) begin
                            r_mis      <= (r_mis == 16'hFFFF) ? r_mis : r_mis + 16'd1;
                            r_fail_adr <= r_cur;
`ifdef WB_MTEST_HALT_ON_FAIL_EN
                            r_fault    <= 1'b1;
                            r_state    <= S_IDLE;
`endif
                        end
                    end else if (err_i || r_tcnt == TO_LIM) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        if (r_retry == RT_LIM) begin
                            r_fault    <= 1'b1;
                            r_fail_adr <= r_cur;
                            r_retry    <= '0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_retry <= r_retry + RW'(1);
                            r_state <= S_REQ;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_NEXT: begin
                    r_cur <= w_wrap ? A_START : w_nxt[ADDR_WIDTH-1:0];
                    if (w_wrap) begin
                        r_rd <= ~r_rd;
                        if (r_rd) begin
                            r_pass_done <= 1'b1;
                            r_pass_cnt  <= r_pass_cnt + 16'd1;
                        end
                    end
                    r_state <= en_i ? S_REQ : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cyc_o          = r_cyc;
    assign stb_o          = r_stb;
    assign we_o           = r_we;
    assign adr_o          = r_adr;
    assign dat_o          = r_dat;
    assign sel_o          = '1;
    assign busy_o         = (r_state != S_IDLE) && (r_state != S_WAIT_INIT);
    assign pass_done_o    = r_pass_done;
    assign pass_cnt_o     = r_pass_cnt;
    assign mismatch_cnt_o = r_mis;
    assign fault_o        = r_fault;
    assign fail_adr_o     = r_fail_adr;
endmodule
